sa_axi4_full_slave_mem: RTL



---
 rtl/sa_axi4_full_slave_mem.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sa_axi4_full_slave_mem.sv
// AXI4-Full INCR-burst responder backed by a 128-bit word memory; write and read channels run independently.
// Define AXI_SLAVE_RANGE_CHECK_EN to answer out-of-range bursts with SLVERR instead of wrapping.
module sa_axi4_full_slave_mem #(
    parameter int                            C_S_AXI_ID_WIDTH   = 1,
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 128,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] MEM_BASE_ADDR      = 32'h40000000,
    parameter int                            MEM_DEPTH          = 1024
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                        s_axi_awlen,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wlast,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                        s_axi_arlen,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rlast,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [1:0]                        o_dbg_wr_state,
    output logic [1:0]                        o_dbg_rd_state
);

    // Valid/ready: a transfer occurs on the rising edge where valid and ready are both high;
    // the source holds its payload stable until then, and every ready/valid here is a flop output.

    localparam int         IDX_W       = $clog2(MEM_DEPTH);
    localparam int         STRB_W      = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t                      r_wstate;
    w_state_t                      w_wstate_nxt;
    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic                          r_w_err;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_bid;
    logic [IDX_W-1:0]              r_widx;
    logic [7:0]                    r_awlen;
    logic [7:0]                    r_wbeat;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_aw_off;
    logic [IDX_W-1:0]              w_aw_idx;
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_b_hs;
    logic                          w_w_last;
    logic                          w_aw_oor;

    // ---------------- read channel ----------------
    r_state_t                      r_rstate;
    r_state_t                      w_rstate_nxt;
    logic                          r_arready;
    logic                          r_rvalid;
    logic                          r_rlast;
    logic                          r_r_err;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_rid;
    logic [IDX_W-1:0]              r_ridx;
    logic [IDX_W-1:0]              w_ridx_nxt;
    logic [7:0]                    r_arlen;
    logic [7:0]                    r_rbeat;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_ar_off;
    logic [IDX_W-1:0]              w_ar_idx;
    logic                          w_ar_hs;
    logic                          w_r_hs;
    logic                          w_r_last;
    logic                          w_ar_oor;

    assign w_aw_off = s_axi_awaddr - MEM_BASE_ADDR;
    assign w_aw_idx = w_aw_off[IDX_W+3:4];
    assign w_ar_off = s_axi_araddr - MEM_BASE_ADDR;
    assign w_ar_idx = w_ar_off[IDX_W+3:4];

    assign w_aw_hs  = s_axi_awvalid & r_awready;
    assign w_w_hs   = s_axi_wvalid & r_wready;
    assign w_b_hs   = r_bvalid & s_axi_bready;
    assign w_w_last = (r_wbeat == r_awlen);

    assign w_ar_hs    = s_axi_arvalid & r_arready;
    assign w_r_hs     = r_rvalid & s_axi_rready;
    assign w_r_last   = (r_rbeat == r_arlen);
    assign w_ridx_nxt = r_ridx + IDX_W'(1);

`ifdef AXI_SLAVE_RANGE_CHECK_EN
    localparam int EXT_W = C_S_AXI_ADDR_WIDTH + 1;
    logic [EXT_W-1:0] w_aw_end;
    logic [EXT_W-1:0] w_ar_end;

    // Last word index of the burst, computed without wrap so a burst crossing the top is caught.
    assign w_aw_end = EXT_W'(w_aw_off >> 4) + EXT_W'(s_axi_awlen);
    assign w_ar_end = EXT_W'(w_ar_off >> 4) + EXT_W'(s_axi_arlen);
    assign w_aw_oor = (s_axi_awaddr < MEM_BASE_ADDR) || (w_aw_end >= EXT_W'(MEM_DEPTH));
    assign w_ar_oor = (s_axi_araddr < MEM_BASE_ADDR) || (w_ar_end >= EXT_W'(MEM_DEPTH));
`else
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;
`endif

    // Byte offset within a word and wlast are deliberately ignored; bursts end on the beat count.
    logic w_unused;
    assign w_unused = ^{s_axi_wlast, w_aw_off[3:0], w_ar_off[3:0],
                        w_aw_off[C_S_AXI_ADDR_WIDTH-1:IDX_W+4],
                        w_ar_off[C_S_AXI_ADDR_WIDTH-1:IDX_W+4]};

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_last) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_w_err   <= 1'b0;
            r_bid     <= '0;
            r_widx    <= '0;
            r_awlen   <= '0;
            r_wbeat   <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_bid   <= s_axi_awid;
                r_widx  <= w_aw_idx;
                r_awlen <= s_axi_awlen;
                r_wbeat <= '0;
                r_w_err <= w_aw_oor;
            end
            if (w_w_hs) begin
                r_widx  <= r_widx + IDX_W'(1);
                r_wbeat <= r_wbeat + 8'd1;
            end
        end
    end

    // Storage is never reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_w_hs && !r_w_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi_wstrb[i]) begin
                    r_mem[r_widx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_FETCH;
            R_FETCH: w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_r_last) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Non-blocking memory reads see the pre-write word when both channels hit it on one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_r_err   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_rid     <= '0;
            r_ridx    <= '0;
            r_arlen   <= '0;
            r_rbeat   <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_rid   <= s_axi_arid;
                r_ridx  <= w_ar_idx;
                r_arlen <= s_axi_arlen;
                r_rbeat <= '0;
                r_r_err <= w_ar_oor;
            end
            if (r_rstate == R_FETCH) begin
                r_rvalid <= 1'b1;
                r_rlast  <= w_r_last;
                r_rresp  <= r_r_err ? RESP_SLVERR : RESP_OKAY;
                r_rdata  <= r_r_err ? '0 : r_mem[r_ridx];
            end else if (w_r_hs) begin
                if (w_r_last) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end else begin
                    r_ridx  <= w_ridx_nxt;
                    r_rbeat <= r_rbeat + 8'd1;
                    r_rlast <= ((r_rbeat + 8'd1) == r_arlen);
                    r_rdata <= r_r_err ? '0 : r_mem[w_ridx_nxt];
                end
            end
        end
    end

    assign s_axi_awready  = r_awready;
    assign s_axi_wready   = r_wready;
    assign s_axi_bvalid   = r_bvalid;
    assign s_axi_bid      = r_bid;
    assign s_axi_bresp    = r_w_err ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_arready  = r_arready;
    assign s_axi_rvalid   = r_rvalid;
    assign s_axi_rlast    = r_rlast;
    assign s_axi_rid      = r_rid;
    assign s_axi_rresp    = r_rresp;
    assign s_axi_rdata    = r_rdata;
    assign o_dbg_wr_state = r_wstate;
    assign o_dbg_rd_state = r_rstate;

endmodule
